weight_mem_ctrl: RTL and testbench
==================================

WEIGHT_MEM_CTRL -- requirements
Module: weight_mem_ctrl

Interface
REQ-001 The block SHALL use one clock `clk` and a synchronous, active-high reset `rst`; no other clock or reset SHALL exist.
REQ-002 Parameters (name, default, meaning) SHALL be:
- DEPTH, 30, number of weight words.
- WIDTH, 9, signed weight width.
- AW, 5, address width.

REQ-003 Ports (name, direction, width, meaning) SHALL be:
- clk, in, 1, clock.
- rst, in, 1, synchronous active-high reset.
- load_start, in, 1, request load phase.
- stream_start, in, 1, request stream phase.
- in_valid, in, 1, load word valid.
- in_data, in, WIDTH, signed load word.
- in_ready, out, 1, load word accepted this cycle when in_valid.
- mem_write, out, 1, memory write enable.
- mem_read, out, 1, memory read enable.
- mem_address, out, AW, memory address.
- mem_datain, out, WIDTH, memory write data.
- mem_dataout, in, WIDTH, memory read data, registered, 1-cycle latency, 0 when not read.
- out_valid, out, 1, streamed weight valid.
- out_data, out, WIDTH, streamed signed weight.
- out_last, out, 1, final streamed weight.
- busy, out, 1, phase in progress.
- done, out, 1, one-cycle phase-complete pulse.

Function
REQ-004 The FSM SHALL have states IDLE, LOAD, READ, DRAIN; busy SHALL be 1 in every state except IDLE.
REQ-005 In IDLE, load_start=1 SHALL enter LOAD next cycle; otherwise stream_start=1 SHALL enter READ next cycle; if both are 1, load SHALL win and stream_start SHALL be dropped.
REQ-006 load_start/stream_start SHALL be ignored outside IDLE.
REQ-007 Entry to LOAD or READ SHALL clear the word counter to 0.
REQ-008 In LOAD: in_ready=1; on in_valid=1 the same cycle drives mem_write=1, mem_address=counter, mem_datain=in_data, and the counter increments.
- in_valid=0 SHALL stall with mem_write=0.

REQ-009 The accept of word DEPTH-1 SHALL return the FSM to IDLE next cycle, with done=1 in that next cycle.
- in_ready SHALL be 0 from that cycle on.

REQ-010 In READ: mem_read=1 and mem_address=counter every cycle, counter 0..DEPTH-1 with no stalls; after address DEPTH-1 the FSM SHALL enter DRAIN.
REQ-011 out_valid SHALL be the 1-cycle-delayed mem_read; out_data SHALL equal mem_dataout when out_valid=1, and 0 otherwise.
REQ-012 DRAIN SHALL last exactly one cycle, then IDLE.
- In DRAIN: out_valid=1, out_last=1, done=1, carrying word DEPTH-1.

REQ-013 Stream latency: stream_start sampled at cycle T gives address k at T+1+k and out_data=word k at T+2+k; out_last/done at T+DEPTH+1.
REQ-014 There SHALL be no output backpressure; the consumer always accepts.
REQ-015 Outside LOAD, mem_write=0; outside READ, mem_read=0; in IDLE, mem_address=0 and mem_datain=0.
REQ-016 The counter SHALL never exceed DEPTH-1 and SHALL never wrap within a phase.
REQ-017 Accepted writes SHALL be unsigned address order only; data SHALL pass unmodified, with sign preserved and no width conversion.

Reset
REQ-018 rst=1 SHALL, at the next edge, force IDLE and counter=0.
- All outputs SHALL then be 0: in_ready, mem_write, mem_read, mem_address, mem_datain, out_valid, out_data, out_last, busy, done.

REQ-019 rst mid-LOAD or mid-READ SHALL abort with no done pulse.
- Already-written memory words SHALL be left unchanged; the controller SHALL issue no clearing writes.

REQ-020 Starts SHALL be sampled only after rst deasserts.

Structure
REQ-021 Package weight_mem_pkg SHALL hold DEPTH, WIDTH, AW defaults and the FSM state enum.
REQ-022 The word counter SHALL be a sub-module weight_addr_counter (clear, enable, terminal-count flag).
REQ-023 The weight memory SHALL NOT be instantiated inside this block; the enclosing top SHALL connect it.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Load 30 words -29..0 with in_valid held 1 -> 30 writes at addresses 0..29; done at load_start cycle +31; busy 0 after.
- Load with in_valid toggling 1/0 -> mem_write only on valid cycles; addresses contiguous 0..29; done once after the 30th accept.
- Stream after load -> out_data sequence -29..0; out_valid for 30 consecutive cycles starting T+2; out_last and done at T+31.
- load_start and stream_start both 1 in IDLE -> LOAD entered, no mem_read; stream_start during LOAD ignored.
- rst at stream word 10 -> all outputs 0 next cycle, no done; a new stream then restarts at address 0.
- Write all words 255 (max positive) and all words -256 (min negative), then stream -> values returned bit-exact.

Source files
------------

// File: rtl/weight_mem_pkg.sv
// Shared defaults and FSM encoding for the weight memory controller.
package weight_mem_pkg;

    localparam int DEFAULT_DEPTH = 30;
    localparam int DEFAULT_WIDTH = 9;
    localparam int DEFAULT_AW    = 5;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        READ,
        DRAIN
    } ctrl_state_t;

endpackage

// File: rtl/weight_addr_counter.sv
// Word counter for load/stream phases; saturates at DEPTH-1 so it never wraps.
module weight_addr_counter #(
    parameter int DEPTH = 30,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          enable,
    output logic [AW-1:0] count,
    output logic          tc
);

    assign tc = (count == AW'(DEPTH - 1));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && !tc) begin
            count <= count + AW'(1);
        end
    end

endmodule

// File: rtl/weight_mem_ctrl.sv
// Sequences weight loads into an external memory and streams them back out in
// address order; the memory itself lives in the enclosing top.
module weight_mem_ctrl
    import weight_mem_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int AW    = DEFAULT_AW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_start,
    input  logic             stream_start,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             mem_write,
    output logic             mem_read,
    output logic [AW-1:0]    mem_address,
    output logic [WIDTH-1:0] mem_datain,
    input  logic [WIDTH-1:0] mem_dataout,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             busy,
    output logic             done
);

    ctrl_state_t     state;
    ctrl_state_t     state_next;
    logic [AW-1:0]   count;
    logic            tc;
    logic            cnt_en;
    logic            load_done_q;
    logic            read_q;

    // Counter is held at zero throughout IDLE, so every phase starts at address 0.
    weight_addr_counter #(
        .DEPTH(DEPTH),
        .AW   (AW)
    ) u_counter (
        .clk   (clk),
        .rst   (rst),
        .clear (state == IDLE),
        .enable(cnt_en),
        .count (count),
        .tc    (tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            load_done_q <= 1'b0;
            read_q      <= 1'b0;
        end else begin
            state       <= state_next;
            load_done_q <= (state == LOAD) && in_valid && tc;
            read_q      <= mem_read;
        end
    end

    always_comb begin
        state_next  = state;
        in_ready    = 1'b0;
        mem_write   = 1'b0;
        mem_read    = 1'b0;
        mem_address = '0;
        mem_datain  = '0;
        cnt_en      = 1'b0;
        case (state)
            IDLE: begin
                if (load_start) begin
                    state_next = LOAD;
                end else if (stream_start) begin
                    state_next = READ;
                end
            end
            LOAD: begin
                in_ready    = 1'b1;
                mem_address = count;
                if (in_valid) begin
                    mem_write  = 1'b1;
                    mem_datain = in_data;
                    cnt_en     = 1'b1;
                    if (tc) begin
                        state_next = IDLE;
                    end
                end
            end
            READ: begin
                mem_read    = 1'b1;
                mem_address = count;
                cnt_en      = 1'b1;
                if (tc) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Read data arrives one cycle after the address, so validity trails mem_read.
    assign out_valid = read_q;
    assign out_data  = read_q ? mem_dataout : '0;
    assign out_last  = (state == DRAIN);
    assign busy      = (state != IDLE);
    assign done      = load_done_q || (state == DRAIN);

endmodule

// File: tb/tb_weight_mem_ctrl.sv
// Self-checking bench for weight_mem_ctrl with a behavioural registered memory.
module tb_weight_mem_ctrl;

    localparam int DEPTH = 30;
    localparam int WIDTH = 9;
    localparam int AW    = 5;

    typedef struct {
        int rst;  int ls;    int ss;  int iv;  int id;
        int busy; int ready; int wr;  int rd;  int addr;
        int din;  int ov;    int od;  int last; int done;
    } vec_t;

    logic             clk;
    logic             rst;
    logic             load_start;
    logic             stream_start;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             mem_write;
    logic             mem_read;
    logic [AW-1:0]    mem_address;
    logic [WIDTH-1:0] mem_datain;
    logic [WIDTH-1:0] mem_dataout;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic             busy;
    logic             done;

    logic [WIDTH-1:0] mem [DEPTH];
    logic signed [WIDTH-1:0] sb [$];
    vec_t tbl [12];
    int vectors;
    int miscompares;

    weight_mem_ctrl #(
        .DEPTH(DEPTH),
        .WIDTH(WIDTH),
        .AW   (AW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .load_start  (load_start),
        .stream_start(stream_start),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .mem_write   (mem_write),
        .mem_read    (mem_read),
        .mem_address (mem_address),
        .mem_datain  (mem_datain),
        .mem_dataout (mem_dataout),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_last    (out_last),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered read with one-cycle latency, zero when not reading.
    always_ff @(posedge clk) begin
        if (mem_write) mem[mem_address] <= mem_datain;
        mem_dataout <= mem_read ? mem[mem_address] : '0;
    end

    function automatic logic signed [WIDTH-1:0] wordFor(input int mode, input int k);
        case (mode)
            0:       return WIDTH'(k - 29);
            1:       return 9'h0ff;
            default: return 9'h100;
        endcase
    endfunction

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit r, input bit ls, input bit ss, input bit iv, input int d);
        rst          = r;
        load_start   = ls;
        stream_start = ss;
        in_valid     = iv;
        in_data      = WIDTH'(d);
        #1;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " in_ready"}, int'(in_ready), 0);
        checkOutput({tag, " mem_write"}, int'(mem_write), 0);
        checkOutput({tag, " mem_read"}, int'(mem_read), 0);
        checkOutput({tag, " mem_address"}, int'(mem_address), 0);
        checkOutput({tag, " mem_datain"}, int'(mem_datain), 0);
        checkOutput({tag, " out_valid"}, int'(out_valid), 0);
        checkOutput({tag, " out_data"}, int'(out_data), 0);
        checkOutput({tag, " out_last"}, int'(out_last), 0);
        checkOutput({tag, " busy"}, int'(busy), 0);
        checkOutput({tag, " done"}, int'(done), 0);
    endtask

    task automatic doLoad(input int mode, input bit toggle, input string tag);
        int count;
        int c;
        bit v;
        logic signed [WIDTH-1:0] d;
        count = 0;
        c = 0;
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput({tag, " start busy"}, int'(busy), 0);
        while (count < DEPTH) begin
            nextCycle();
            c++;
            v = !toggle || (c % 2 == 1);
            d = v ? wordFor(mode, count) : '0;
            applyStimulus(0, 0, 0, v, int'(d));
            checkOutput($sformatf("%s c%0d in_ready", tag, c), int'(in_ready), 1);
            checkOutput($sformatf("%s c%0d busy", tag, c), int'(busy), 1);
            checkOutput($sformatf("%s c%0d mem_write", tag, c), int'(mem_write), int'(v));
            checkOutput($sformatf("%s c%0d mem_read", tag, c), int'(mem_read), 0);
            checkOutput($sformatf("%s c%0d done", tag, c), int'(done), 0);
            if (v) begin
                checkOutput($sformatf("%s c%0d address", tag, c), int'(mem_address), count);
                checkOutput($sformatf("%s c%0d datain", tag, c), int'($signed(mem_datain)), int'(d));
                count++;
            end
        end
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput({tag, " done pulse"}, int'(done), 1);
        checkOutput({tag, " busy after"}, int'(busy), 0);
        checkOutput({tag, " in_ready after"}, int'(in_ready), 0);
        checkOutput({tag, " mem_write after"}, int'(mem_write), 0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput({tag, " done single"}, int'(done), 0);
        nextCycle();
    endtask

    task automatic doStream(input int mode, input int abort_word, input string tag);
        logic signed [WIDTH-1:0] exp_word;
        bit rst_now;
        sb.delete();
        applyStimulus(0, 0, 1, 0, 0);
        checkOutput({tag, " start busy"}, int'(busy), 0);
        for (int k = 0; k < DEPTH; k++) sb.push_back(wordFor(mode, k));
        for (int c = 1; c <= DEPTH + 3; c++) begin
            nextCycle();
            rst_now = (abort_word < DEPTH) && (c == abort_word + 2);
            applyStimulus(rst_now, 0, 0, 0, 0);
            checkOutput($sformatf("%s c%0d mem_read", tag, c), int'(mem_read), (c <= DEPTH) ? 1 : 0);
            checkOutput($sformatf("%s c%0d address", tag, c), int'(mem_address), (c <= DEPTH) ? c - 1 : 0);
            checkOutput($sformatf("%s c%0d busy", tag, c), int'(busy), (c <= DEPTH + 1) ? 1 : 0);
            checkOutput($sformatf("%s c%0d out_valid", tag, c), int'(out_valid), (c >= 2 && c <= DEPTH + 1) ? 1 : 0);
            checkOutput($sformatf("%s c%0d out_last", tag, c), int'(out_last), (c == DEPTH + 1) ? 1 : 0);
            checkOutput($sformatf("%s c%0d done", tag, c), int'(done), (c == DEPTH + 1) ? 1 : 0);
            if (out_valid) begin
                if (sb.size() == 0) begin
                    checkOutput($sformatf("%s c%0d extra word", tag, c), 1, 0);
                end else begin
                    exp_word = sb.pop_front();
                    checkOutput($sformatf("%s c%0d out_data", tag, c), int'($signed(out_data)), int'(exp_word));
                end
            end else begin
                checkOutput($sformatf("%s c%0d idle out_data", tag, c), int'(out_data), 0);
            end
            if (rst_now) begin
                nextCycle();
                applyStimulus(0, 0, 0, 0, 0);
                checkAllZero({tag, " post-reset"});
                for (int i = 0; i < 3; i++) begin
                    nextCycle();
                    applyStimulus(0, 0, 0, 0, 0);
                    checkOutput($sformatf("%s no done %0d", tag, i), int'(done), 0);
                end
                nextCycle();
                sb.delete();
                return;
            end
        end
        checkOutput({tag, " words left"}, sb.size(), 0);
        nextCycle();
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        // rst ls ss iv id | busy ready wr rd addr din ov od last done
        tbl = '{
            '{1, 0, 0, 0,  0,  0, 0, 0, 0, 0,  0, 0,  0, 0, 0},
            '{0, 1, 1, 0,  0,  0, 0, 0, 0, 0,  0, 0,  0, 0, 0},
            '{0, 0, 1, 1,  5,  1, 1, 1, 0, 0,  5, 0,  0, 0, 0},
            '{0, 0, 0, 0,  0,  1, 1, 0, 0, 1,  0, 0,  0, 0, 0},
            '{0, 0, 0, 1, -3,  1, 1, 1, 0, 1, -3, 0,  0, 0, 0},
            '{1, 1, 0, 1,  9,  1, 1, 1, 0, 2,  9, 0,  0, 0, 0},
            '{0, 0, 0, 0,  0,  0, 0, 0, 0, 0,  0, 0,  0, 0, 0},
            '{0, 0, 1, 0,  0,  0, 0, 0, 0, 0,  0, 0,  0, 0, 0},
            '{0, 1, 0, 0,  0,  1, 0, 0, 1, 0,  0, 0,  0, 0, 0},
            '{0, 0, 0, 0,  0,  1, 0, 0, 1, 1,  0, 1,  5, 0, 0},
            '{1, 0, 0, 0,  0,  1, 0, 0, 1, 2,  0, 1, -3, 0, 0},
            '{0, 0, 0, 0,  0,  0, 0, 0, 0, 0,  0, 0,  0, 0, 0}
        };

        rst = 1'b1; load_start = 1'b0; stream_start = 1'b0; in_valid = 1'b0; in_data = '0;
        nextCycle();
        nextCycle();

        for (int i = 0; i < 12; i++) begin
            applyStimulus(bit'(tbl[i].rst), bit'(tbl[i].ls), bit'(tbl[i].ss), bit'(tbl[i].iv), tbl[i].id);
            checkOutput($sformatf("v%0d busy", i), int'(busy), tbl[i].busy);
            checkOutput($sformatf("v%0d in_ready", i), int'(in_ready), tbl[i].ready);
            checkOutput($sformatf("v%0d mem_write", i), int'(mem_write), tbl[i].wr);
            checkOutput($sformatf("v%0d mem_read", i), int'(mem_read), tbl[i].rd);
            checkOutput($sformatf("v%0d mem_address", i), int'(mem_address), tbl[i].addr);
            checkOutput($sformatf("v%0d mem_datain", i), int'($signed(mem_datain)), tbl[i].din);
            checkOutput($sformatf("v%0d out_valid", i), int'(out_valid), tbl[i].ov);
            checkOutput($sformatf("v%0d out_data", i), int'($signed(out_data)), tbl[i].od);
            checkOutput($sformatf("v%0d out_last", i), int'(out_last), tbl[i].last);
            checkOutput($sformatf("v%0d done", i), int'(done), tbl[i].done);
            nextCycle();
        end

        doLoad(0, 1'b0, "load ramp");
        doStream(0, DEPTH, "stream ramp");
        doLoad(0, 1'b1, "load toggle");
        doStream(0, DEPTH, "stream toggle");
        doStream(0, 10, "stream abort");
        doStream(0, DEPTH, "stream restart");
        doLoad(1, 1'b0, "load max");
        doStream(1, DEPTH, "stream max");
        doLoad(2, 1'b0, "load min");
        doStream(2, DEPTH, "stream min");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
